// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Purpose  : Frame scheduler for the game datapath. Runs the input-sampling,
//            game-action and display-refresh units in turn through
//            enable/done handshakes. Each frame is padded to a minimum cycle
//            budget, and an optional watchdog bounds every phase.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FRAME_LEN    minimum cycles from one INPUT entry to the next (>= 4)
//   TIMEOUT      maximum cycles per phase before the watchdog fires (>= 2)
// Build option
//   SEQ_WATCHDOG_EN  when defined, adds the phase counter and the watchdog.
//                    When undefined, each phase waits for its done without a
//                    limit and timeout_o is tied to 0.
// Ports
//   clk_i        clock; all logic runs on the rising edge
//   rst_i        synchronous active-high reset
//   run_i        run request; sampled in IDLE and at frame boundaries
//   d_inp_i      input unit done
//   d_act_i      action unit done
//   d_disp_i     display unit done
//   e_inp_o      input unit enable (INPUT only)
//   e_act_o      action unit enable (ACTION only)
//   e_disp_o     display unit enable (DISPLAY only)
//   frame_o      one-cycle pulse after a DISPLAY phase ends
//   frame_cnt_o  completed-frame count, wraps 255 -> 0
//   timeout_o    sticky watchdog flag, cleared only by reset
//   state_o      IDLE=0, INPUT=1, ACTION=2, DISPLAY=3, WAIT=4
// ============================================================================
module game_sequencer #(
   parameter int FRAME_LEN = 16384,
   parameter int TIMEOUT   = 4096
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       run_i,
   input  logic       d_inp_i,
   input  logic       d_act_i,
   input  logic       d_disp_i,
   output logic       e_inp_o,
   output logic       e_act_o,
   output logic       e_disp_o,
   output logic       frame_o,
   output logic [7:0] frame_cnt_o,
   output logic       timeout_o,
   output logic [2:0] state_o
);

   localparam int              c_TW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [c_TW-1:0] c_TMAX = c_TW'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INPUT   = 3'd1,
      ST_ACTION  = 3'd2,
      ST_DISPLAY = 3'd3,
      ST_WAIT    = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [c_TW-1:0] r_timer;
   logic            w_tmr_full;
   logic            w_done;
   logic            w_wd_hit;
   logic            w_adv;
   logic            w_disp_end;
   logic            r_e_inp;
   logic            r_e_act;
   logic            r_e_disp;
   logic            r_frame;
   logic [7:0]      r_frame_cnt;

   assign w_tmr_full = (r_timer == c_TMAX);

   // Only the done of the unit that owns the current phase is seen.
   always_comb begin
      w_done = 1'b0;
      case (r_state)
         ST_INPUT:   w_done = d_inp_i;
         ST_ACTION:  w_done = d_act_i;
         ST_DISPLAY: w_done = d_disp_i;
         default:    w_done = 1'b0;
      endcase
   end

`ifdef SEQ_WATCHDOG_EN
   localparam int              c_PW   = $clog2(TIMEOUT);
   localparam logic [c_PW-1:0] c_PMAX = c_PW'(TIMEOUT - 1);

   logic [c_PW-1:0] r_phase;
   logic            r_timeout;
   logic            w_fire;

   // The phase counter stays 0 in IDLE and WAIT and TIMEOUT >= 2, so a hit
   // can only occur in one of the three handshake phases.
   assign w_wd_hit = (r_phase == c_PMAX);
   // A done arriving on the expiry cycle wins; the flag is not raised.
   assign w_fire   = w_wd_hit & ~w_done;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_phase   <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_next != r_state) begin
            r_phase <= '0;
         end else if ((r_state == ST_INPUT) || (r_state == ST_ACTION) ||
                      (r_state == ST_DISPLAY)) begin
            r_phase <= r_phase + c_PW'(1);
         end
         if (w_fire) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign timeout_o = r_timeout;
`else
   assign w_wd_hit  = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // An expired watchdog moves the FSM on exactly as a done would.
   assign w_adv = w_done | w_wd_hit;

   always_comb begin
      w_next     = r_state;
      w_disp_end = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (run_i) w_next = ST_INPUT;
         end
         ST_INPUT: begin
            if (w_adv) w_next = ST_ACTION;
         end
         ST_ACTION: begin
            if (w_adv) w_next = ST_DISPLAY;
         end
         ST_DISPLAY: begin
            if (w_adv) begin
               w_disp_end = 1'b1;
               // Budget already used up: skip WAIT and start the next frame.
               if (w_tmr_full) begin
                  if (run_i) w_next = ST_INPUT;
                  else       w_next = ST_IDLE;
               end else begin
                  w_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (w_tmr_full) begin
               if (run_i) w_next = ST_INPUT;
               else       w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Enables are registered from the next state so they line up with
   // state_o and hand off on a single edge with no gap or overlap.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_e_inp     <= 1'b0;
         r_e_act     <= 1'b0;
         r_e_disp    <= 1'b0;
         r_frame     <= 1'b0;
         r_frame_cnt <= 8'd0;
      end else begin
         r_state  <= w_next;
         r_e_inp  <= (w_next == ST_INPUT);
         r_e_act  <= (w_next == ST_ACTION);
         r_e_disp <= (w_next == ST_DISPLAY);
         r_frame  <= w_disp_end;
         if (w_disp_end) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
         // The INPUT entry edge is timer value 0; the timer then counts up
         // and saturates so the frame-boundary compare stays valid.
         if ((w_next == ST_INPUT) && (r_state != ST_INPUT)) begin
            r_timer <= '0;
         end else if ((r_state != ST_IDLE) && !w_tmr_full) begin
            r_timer <= r_timer + c_TW'(1);
         end
      end
   end

   assign e_inp_o     = r_e_inp;
   assign e_act_o     = r_e_act;
   assign e_disp_o    = r_e_disp;
   assign frame_o     = r_frame;
   assign frame_cnt_o = r_frame_cnt;
   assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Purpose  : Self-checking bench for game_sequencer (FRAME_LEN=16,
//            TIMEOUT=8). Behavioural unit responders return done after a
//            programmable number of enabled cycles. Expected frame counts and
//            frame periods are queued as stimulus is set up and compared
//            when the DUT produces frame pulses and INPUT entries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

   localparam int c_FL = 16;
   localparam int c_TO = 8;

   logic       clk      = 1'b0;
   logic       rst_i    = 1'b1;
   logic       run_i    = 1'b0;
   logic       d_inp_i  = 1'b0;
   logic       d_act_i  = 1'b0;
   logic       d_disp_i = 1'b0;
   logic       e_inp_o;
   logic       e_act_o;
   logic       e_disp_o;
   logic       frame_o;
   logic [7:0] frame_cnt_o;
   logic       timeout_o;
   logic [2:0] state_o;

   game_sequencer #(
      .FRAME_LEN (c_FL),
      .TIMEOUT   (c_TO)
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .run_i       (run_i),
      .d_inp_i     (d_inp_i),
      .d_act_i     (d_act_i),
      .d_disp_i    (d_disp_i),
      .e_inp_o     (e_inp_o),
      .e_act_o     (e_act_o),
      .e_disp_o    (e_disp_o),
      .frame_o     (frame_o),
      .frame_cnt_o (frame_cnt_o),
      .timeout_o   (timeout_o),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- unit responders ----------------
   // lat = N : done on the N-th enabled cycle; 0 : done every enabled cycle;
   // -1 : never. stray_* inject a done regardless of the enable.
   int   lat_inp = 1, lat_act = 1, lat_disp = 1;
   int   k_inp = 0, k_act = 0, k_disp = 0;
   logic stray_act = 1'b0, stray_disp = 1'b0;

   always @(negedge clk) begin
      k_inp  = e_inp_o  ? k_inp  + 1 : 0;
      k_act  = e_act_o  ? k_act  + 1 : 0;
      k_disp = e_disp_o ? k_disp + 1 : 0;
      d_inp_i  = e_inp_o && (lat_inp == 0 || k_inp == lat_inp);
      d_act_i  = (e_act_o && (lat_act == 0 || k_act == lat_act)) || stray_act;
      d_disp_i = (e_disp_o && (lat_disp == 0 || k_disp == lat_disp)) || stray_disp;
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      int period;
      int waits;
   } per_t;

   per_t       per_q[$];
   logic [7:0] cnt_q[$];
   per_t       p_cur;
   int         cyc = 0;
   int         last_entry = 0;
   bit         have_last = 1'b0;
   int         wcnt = 0;
   int         n_entry = 0;
   int         n_frame = 0;
   logic [2:0] prev_state = 3'd0;
   logic       prev_frame = 1'b0;

   function automatic logic [2:0] exp_en(input logic [2:0] s);
      case (s)
         3'd1:    return 3'b100;
         3'd2:    return 3'b010;
         3'd3:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   always @(posedge clk) begin
      cyc++;
      #1;
      if (rst_i) begin
         have_last  = 1'b0;
         prev_state = 3'd0;
         prev_frame = 1'b0;
      end else begin
         chk("en_decode", {29'd0, e_inp_o, e_act_o, e_disp_o}, {29'd0, exp_en(state_o)});
         if (state_o == 3'd4) wcnt++;
         if (state_o == 3'd1 && prev_state != 3'd1) begin
            n_entry++;
            if (have_last && per_q.size() > 0) begin
               p_cur = per_q.pop_front();
               chk("period", cyc - last_entry, p_cur.period);
               chk("wait_cycles", wcnt, p_cur.waits);
            end
            last_entry = cyc;
            have_last  = 1'b1;
            wcnt       = 0;
         end
         if (state_o == 3'd0) have_last = 1'b0;
         if (frame_o) begin
            n_frame++;
            if (cnt_q.size() > 0) chk("frame_cnt", frame_cnt_o, cnt_q.pop_front());
            else                  chk("frame_unexpected", frame_o, 0);
            chk("frame_width", prev_frame, 0);
         end
         prev_state = state_o;
         prev_frame = frame_o;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (state_o == s) begin
            found = 1'b1;
            break;
         end
      end
      chk($sformatf("reach_state%0d", s), found, 1);
   endtask

   task automatic push_per(input int n, input int period, input int waits);
      per_t p;
      p.period = period;
      p.waits  = waits;
      for (int i = 0; i < n; i++) per_q.push_back(p);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_state"}, state_o, 0);
      chk({tag, "_en"}, {e_inp_o, e_act_o, e_disp_o}, 0);
      chk({tag, "_frame"}, frame_o, 0);
      chk({tag, "_cnt"}, frame_cnt_o, 0);
      chk({tag, "_timeout"}, timeout_o, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      int         e0;
      int         f0;
      int         t0;
      int         n_act;
      logic [7:0] v;

      // ---- reset and start ----
      rst_i = 1'b1;
      run_i = 1'b0;
      tick();
      chk_reset("rst1");
      tick();
      chk_reset("rst2");
      rst_i = 1'b0;
      run_i = 1'b1;
      tick();
      chk("start_state", state_o, 1);
      chk("start_e_inp", e_inp_o, 1);

      // ---- fast units: 1-cycle phases, 13 WAIT cycles, 16-cycle period ----
      push_per(3, 16, 13);
      for (int k = 1; k <= 4; k++) begin
         v = k[7:0];
         cnt_q.push_back(v);
      end
      for (int i = 0; i < 60 && n_frame < 3; i++) tick();
      chk("fast_frames", n_frame, 3);
      wait_state(3'd1, 20);
      // ---- run dropped mid-ACTION: frame 4 completes, then IDLE ----
      wait_state(3'd2, 5);
      run_i = 1'b0;
      wait_state(3'd0, 40);
      chk("stop_cnt", frame_cnt_o, 4);
      chk("stop_queue", per_q.size() + cnt_q.size(), 0);
      repeat (3) tick();
      chk("stop_idle", state_o, 0);

      // ---- stray dones during INPUT, input done exactly at phase count 7 ----
      lat_inp = 8;
      cnt_q.push_back(8'd5);
      run_i = 1'b1;
      tick();
      chk("stray_entry", state_o, 1);
      t0 = cyc;
      stray_act  = 1'b1;
      stray_disp = 1'b1;
      tick();
      tick();
      stray_act  = 1'b0;
      stray_disp = 1'b0;
      chk("stray_ignored", state_o, 1);
      wait_state(3'd2, 20);
      chk("collide_len", cyc - t0, 8);
      chk("collide_timeout", timeout_o, 0);
      run_i = 1'b0;
      wait_state(3'd0, 40);

      // ---- overrun: 6+7+7 = 20 cycles, no WAIT ----
      lat_inp  = 6;
      lat_act  = 7;
      lat_disp = 7;
      push_per(2, 20, 0);
      cnt_q.push_back(8'd6);
      cnt_q.push_back(8'd7);
      cnt_q.push_back(8'd8);
      run_i = 1'b1;
      wait_state(3'd1, 5);
      e0 = n_entry;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (n_entry >= e0 + 2) break;
      end
      chk("ovr_entries", n_entry - e0, 2);
      run_i = 1'b0;
      wait_state(3'd0, 40);
      chk("ovr_cnt", frame_cnt_o, 8);
      chk("ovr_queue", per_q.size() + cnt_q.size(), 0);

      // ---- watchdog on a stuck action unit ----
      lat_inp  = 1;
      lat_act  = -1;
      lat_disp = 1;
      cnt_q.push_back(8'd9);
      run_i = 1'b1;
      wait_state(3'd2, 10);
      run_i = 1'b0;
      n_act = 1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (state_o == 3'd2) n_act++;
         else break;
      end
`ifdef SEQ_WATCHDOG_EN
      chk("wd_act_len", n_act, 8);
      chk("wd_e_disp", e_disp_o, 1);
      chk("wd_flag", timeout_o, 1);
      wait_state(3'd0, 40);
      chk("wd_sticky", timeout_o, 1);
`else
      chk("nowd_act_len", n_act, 31);
      chk("nowd_e_act", e_act_o, 1);
      chk("nowd_flag", timeout_o, 0);
      lat_act = 0;
      wait_state(3'd0, 40);
      chk("nowd_flag2", timeout_o, 0);
`endif
      chk("wd_cnt", frame_cnt_o, 9);

      // ---- reset in DISPLAY ----
      lat_act  = 1;
      lat_disp = -1;
      run_i = 1'b1;
      wait_state(3'd3, 10);
      tick();
      rst_i = 1'b1;
      tick();
      chk_reset("midrst");

      // ---- 256 frames wrap frame_cnt_o to 0 ----
      lat_disp = 1;
      for (int k = 1; k <= 256; k++) begin
         v = k[7:0];
         cnt_q.push_back(v);
      end
      push_per(255, 16, 13);
      f0 = n_frame;
      rst_i = 1'b0;
      for (int i = 0; i < 256 * c_FL + 40; i++) begin
         tick();
         if (n_frame >= f0 + 256) break;
      end
      chk("wrap_frames", n_frame - f0, 256);
      run_i = 1'b0;
      chk("wrap_cnt", frame_cnt_o, 0);
      wait_state(3'd0, 40);
      chk("wrap_queue", per_q.size() + cnt_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
